// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Runtime-programmable serial bit-sequence detector. A pattern of up to
//   MAX_LEN bits (LSB-aligned, pat[len-1] received first) is compared against
//   the recent qualified input history. Overlapping or non-overlapping
//   detection is selected live by 'overlap'. It also keeps a saturating match
//   counter and reports match progress on 'state'.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   qualifies 'in'; a bit is accepted when in_valid=1 and cfg_load=0
//   in         serial data bit
//   cfg_load   loads pat/pat_len (length clamped to MAX_LEN), clears history
//   pat        pattern, LSB-aligned
//   pat_len    pattern length (0 disables detection)
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   cnt_clr    synchronous clear of match_cnt
//   match      one-cycle pulse per detected pattern (registered)
//   match_cnt  saturating match count (registered)
//   state      number of pattern bits currently matched (decoded from registers)
//
// Handshake: 'in' is consumed on a rising edge where in_valid=1 and cfg_load=0.
// There is no backpressure; the detector accepts every qualified bit.

module seq_detect_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(7'b1110010),
  parameter int                 DEF_LEN = 7,
  localparam int                LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LW-1:0]      pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LW-1:0]      state
);

  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      fill_q;
  logic [LW-1:0]      fill_inc;
  logic [LW-1:0]      fill_d;
  logic [LW-1:0]      state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               match_q;
  logic               accept;
  logic               hit;

  assign accept   = in_valid && !cfg_load;
  assign hist_d   = {hist_q[MAX_LEN-2:0], in};
  assign fill_inc = (fill_q >= LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

  // Match test on the post-shift history: the low len_q bits must equal the
  // pattern and enough bits must have arrived since the last clear.
  always_comb begin
    hit = (len_q != '0) && (fill_inc >= len_q);
    for (int j = 0; j < MAX_LEN; j++) begin
      if (j < int'(len_q)) begin
        if (hist_d[j] != pat_q[j]) hit = 1'b0;
      end
    end
  end

  // A non-overlapping match restarts the fill count so the next match must be
  // built entirely from new bits.
  assign fill_d = (hit && !overlap) ? '0 : fill_inc;

  // Progress: longest proper prefix of the pattern that is a suffix of the
  // history, limited by the number of bits received since the last clear.
  // Ascending k means the last hit wins, giving the largest such k.
  always_comb begin
    state_d = '0;
    for (int k = 1; k < MAX_LEN; k++) begin
      logic ok;
      ok = (k < int'(len_q)) && (k <= int'(fill_q));
      if (ok) begin
        for (int j = 0; j < k; j++) begin
          if (hist_q[j] != pat_q[int'(len_q) - k + j]) ok = 1'b0;
        end
      end
      if (ok) state_d = LW'(k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= DEF_PAT;
      len_q   <= LW'(DEF_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= accept && hit;

      // A clear coinciding with a match leaves that match counted.
      if (cnt_clr) begin
        cnt_q <= (accept && hit) ? CNT_W'(1) : '0;
      end else if (accept && hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (cfg_load) begin
        pat_q  <= pat;
        len_q  <= (pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : pat_len;
        hist_q <= '0;
        fill_q <= '0;
      end else if (in_valid) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state     = state_d;

endmodule
